line_fill_buffer: RTL and testbench

// - Parametrised successor of the single-word slot writer: registered SLOT x DATA_W line storage filled one word
//   per beat, critical-word-first with index wrap, per-slot valid mask, and hand-off of the completed line.
// - Sits between the memory/bus response path and the I-cache refill port.
// - Lets the fetch stage read any already-arrived word before the line completes.

---
 rtl/line_fill_buffer.sv | 149 ++++++++++++++
 tb/tb_line_fill_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_buffer.sv
// line_fill_buffer
// Collects one cache line of SLOT words from the memory/bus response path and
// then hands the complete line to the I-cache refill port. The first beat is
// written to the critical word index and later beats follow it, wrapping from
// slot SLOT-1 back to slot 0. A per-slot valid mask lets the fetch stage read
// any word that has already arrived, before the rest of the line is complete.
// Optional feature macro: LFB_FORWARD_EN. When defined, a beat that is being
// written to the slot selected by rd_idx is forwarded to rd_data in the same
// cycle. When undefined, the early-read path sees registered data only.
module line_fill_buffer #(
    parameter int SLOT   = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fill_start,
    input  logic [TAG_W-1:0]              fill_tag,
    input  logic [$clog2(SLOT)-1:0]       fill_first,
    input  logic                          wr_valid,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          line_valid,
    input  logic                          line_ready,
    output logic [SLOT-1:0][DATA_W-1:0]   line_data,
    output logic [TAG_W-1:0]              line_tag,
    output logic [SLOT-1:0]               slot_valid,
    output logic                          busy,
    input  logic [$clog2(SLOT)-1:0]       rd_idx,
    output logic                          rd_hit,
    output logic [DATA_W-1:0]             rd_data
);

    localparam int IDX_W = $clog2(SLOT);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(SLOT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      state_r;
    logic [IDX_W-1:0]            wr_ptr_r;
    logic [IDX_W-1:0]            beat_cnt_r;
    logic [SLOT-1:0]             slot_valid_r;
    logic [SLOT-1:0][DATA_W-1:0] line_data_r;
    logic [TAG_W-1:0]            line_tag_r;

    logic                        wr_ready_s;
    logic                        line_valid_s;
    logic                        busy_s;
    logic                        rd_hit_s;
    logic [DATA_W-1:0]           rd_data_s;

    // Fill sequencer: start a fill, store beats at the wrapping write pointer, hand off the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {IDX_W{1'b0}};
            beat_cnt_r   <= {IDX_W{1'b0}};
            slot_valid_r <= {SLOT{1'b0}};
            line_data_r  <= {(SLOT*DATA_W){1'b0}};
            line_tag_r   <= {TAG_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fill_start) begin
                        line_tag_r   <= fill_tag;
                        wr_ptr_r     <= fill_first;
                        beat_cnt_r   <= {IDX_W{1'b0}};
                        slot_valid_r <= {SLOT{1'b0}};
                        state_r      <= ST_FILL;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (wr_valid) begin
                        line_data_r[wr_ptr_r]  <= wr_data;
                        slot_valid_r[wr_ptr_r] <= 1'b1;
                        // Pointer is exactly IDX_W bits wide, so the add wraps SLOT-1 -> 0.
                        wr_ptr_r               <= wr_ptr_r + IDX_ONE;
                        beat_cnt_r             <= beat_cnt_r + IDX_ONE;
                        if (beat_cnt_r == LAST_BEAT) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                ST_DONE: begin
                    // Data is kept after hand-off; only the arrival mask is cleared.
                    if (line_ready) begin
                        slot_valid_r <= {SLOT{1'b0}};
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r      <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decoded directly from the state register.
    always_comb begin
        wr_ready_s   = (state_r == ST_FILL);
        line_valid_s = (state_r == ST_DONE);
        busy_s       = (state_r != ST_IDLE);
    end

`ifdef LFB_FORWARD_EN
    logic fwd_s;

    // Early read with bypass of the beat currently being written into the requested slot.
    always_comb begin
        fwd_s = wr_valid && wr_ready_s && (wr_ptr_r == rd_idx);
        if (fwd_s) begin
            rd_hit_s  = 1'b1;
            rd_data_s = wr_data;
        end else begin
            rd_hit_s  = slot_valid_r[rd_idx] && busy_s;
            rd_data_s = line_data_r[rd_idx];
        end
    end
`else
    // Early read from registered line storage only.
    always_comb begin
        rd_hit_s  = slot_valid_r[rd_idx] && busy_s;
        rd_data_s = line_data_r[rd_idx];
    end
`endif

    assign wr_ready   = wr_ready_s;
    assign line_valid = line_valid_s;
    assign busy       = busy_s;
    assign line_data  = line_data_r;
    assign line_tag   = line_tag_r;
    assign slot_valid = slot_valid_r;
    assign rd_hit     = rd_hit_s;
    assign rd_data    = rd_data_s;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed self-checking bench for line_fill_buffer (SLOT=8, DATA_W=32, TAG_W=20).
module tb_line_fill_buffer;

    logic             clk;
    logic             rst_n;
    logic             fill_start;
    logic [19:0]      fill_tag;
    logic [2:0]       fill_first;
    logic             wr_valid;
    logic [31:0]      wr_data;
    logic             wr_ready;
    logic             line_valid;
    logic             line_ready;
    logic [7:0][31:0] line_data;
    logic [19:0]      line_tag;
    logic [7:0]       slot_valid;
    logic             busy;
    logic [2:0]       rd_idx;
    logic             rd_hit;
    logic [31:0]      rd_data;

    int n_checks;
    int n_pass;

    logic [7:0][31:0] exp_line;

    line_fill_buffer #(
        .SLOT   (8),
        .DATA_W (32),
        .TAG_W  (20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_start (fill_start),
        .fill_tag   (fill_tag),
        .fill_first (fill_first),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_data  (line_data),
        .line_tag   (line_tag),
        .slot_valid (slot_valid),
        .busy       (busy),
        .rd_idx     (rd_idx),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock edge, then settle 1 unit before inputs change or outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [19:0] tag, input logic [2:0] first);
        fill_start = 1'b1;
        fill_tag   = tag;
        fill_first = first;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic take_line();
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        fill_start = 1'b0;
        fill_tag   = 20'h0;
        fill_first = 3'd0;
        wr_valid   = 1'b0;
        wr_data    = 32'h0;
        line_ready = 1'b0;
        rd_idx     = 3'd0;
        #1;

        // Reset state
        check("rst_busy",       busy,       1'b0);
        check("rst_wr_ready",   wr_ready,   1'b0);
        check("rst_line_valid", line_valid, 1'b0);
        check("rst_slot_valid", slot_valid, 8'h00);
        check("rst_line_tag",   line_tag,   20'h0);
        check("rst_line_data",  line_data,  256'h0);
        check("rst_rd_hit",     rd_hit,     1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a fill after three beats
        start_fill(20'h00055, 3'd0);
        check("mid_busy",     busy,     1'b1);
        check("mid_wr_ready", wr_ready, 1'b1);
        beat(32'h10);
        beat(32'h11);
        beat(32'h12);
        check("mid_slot_valid", slot_valid, 8'h07);
        rst_n = 1'b0;
        #1;
        check("mrst_slot_valid", slot_valid, 8'h00);
        check("mrst_busy",       busy,       1'b0);
        check("mrst_wr_ready",   wr_ready,   1'b0);
        check("mrst_line_valid", line_valid, 1'b0);
        tick();
        rst_n    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'h99;
        tick();
        tick();
        wr_valid = 1'b0;
        check("drop_slot_valid", slot_valid, 8'h00);
        check("drop_busy",       busy,       1'b0);
        check("drop_line_data",  line_data,  256'h0);

        // Critical-word-first fill with wrap: first=5, beats A0..A7
        start_fill(20'h12345, 3'd5);
        beat(32'hA0);
        rd_idx = 3'd5;
        #1;
        check("early_hit5",  rd_hit,  1'b1);
        check("early_data5", rd_data, 32'hA0);
        rd_idx = 3'd6;
        #1;
        check("early_miss6", rd_hit, 1'b0);
        for (int i = 1; i < 7; i++) beat(32'hA0 + 32'(i));
        check("seven_slot_valid", slot_valid, 8'hEF);
        check("seven_line_valid", line_valid, 1'b0);
        beat(32'hA7);
        exp_line = {32'hA2, 32'hA1, 32'hA0, 32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3};
        check("full_line_valid", line_valid, 1'b1);
        check("full_slot_valid", slot_valid, 8'hFF);
        check("full_line_data",  line_data,  exp_line);
        check("full_line_tag",   line_tag,   20'h12345);
        check("full_wr_ready",   wr_ready,   1'b0);

        // Consumer stalls in DONE while extra beats arrive
        wr_valid = 1'b1;
        wr_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_line_valid", line_valid, 1'b1);
            check("hold_line_data",  line_data,  exp_line);
            check("hold_wr_ready",   wr_ready,   1'b0);
        end
        wr_valid = 1'b0;

        // Handshake with a simultaneous fill_start that must be ignored
        fill_start = 1'b1;
        fill_tag   = 20'h00777;
        fill_first = 3'd1;
        take_line();
        fill_start = 1'b0;
        check("take_busy",       busy,       1'b0);
        check("take_line_valid", line_valid, 1'b0);
        check("take_slot_valid", slot_valid, 8'h00);
        check("take_line_data",  line_data,  exp_line);
        check("take_line_tag",   line_tag,   20'h12345);
        rd_idx = 3'd5;
        #1;
        check("idle_rd_hit", rd_hit, 1'b0);

        // fill_start during FILL is ignored
        start_fill(20'hABCDE, 3'd2);
        beat(32'hB0);
        beat(32'hB1);
        fill_start = 1'b1;
        fill_tag   = 20'h00001;
        fill_first = 3'd0;
        beat(32'hB2);
        fill_start = 1'b0;
        for (int i = 3; i < 8; i++) beat(32'hB0 + 32'(i));
        exp_line = {32'hB7, 32'hB6, 32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0};
        exp_line = {exp_line[5:0], exp_line[7:6]};
        check("ign_line_valid", line_valid, 1'b1);
        check("ign_line_tag",   line_tag,   20'hABCDE);
        check("ign_line_data",  line_data,  exp_line);
        take_line();

        // Critical word into slot 7: same-cycle bypass only when forwarding is built in
        start_fill(20'h00003, 3'd7);
        rd_idx   = 3'd7;
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD;
        #1;
`ifdef LFB_FORWARD_EN
        check("fwd_same_hit",  rd_hit,  1'b1);
        check("fwd_same_data", rd_data, 32'hDEAD);
`else
        check("fwd_same_hit",  rd_hit,  1'b0);
`endif
        tick();
        wr_valid = 1'b0;
        check("fwd_next_hit",  rd_hit,  1'b1);
        check("fwd_next_data", rd_data, 32'hDEAD);
        for (int i = 1; i < 8; i++) beat(32'hD0 + 32'(i));
        check("fwd_line_valid", line_valid, 1'b1);
        take_line();

        // Beats with one-cycle gaps: 8 beats over 16 cycles
        start_fill(20'h00004, 3'd0);
        for (int i = 0; i < 16; i++) begin
            wr_valid = ((i % 2) == 0);
            wr_data  = ((i % 2) == 0) ? (32'hC0 + 32'(i / 2)) : 32'hBAD;
            tick();
            if (i == 13) check("gap_not_done", line_valid, 1'b0);
        end
        wr_valid = 1'b0;
        exp_line = {32'hC7, 32'hC6, 32'hC5, 32'hC4, 32'hC3, 32'hC2, 32'hC1, 32'hC0};
        check("gap_line_valid", line_valid, 1'b1);
        check("gap_slot_valid", slot_valid, 8'hFF);
        check("gap_line_data",  line_data,  exp_line);
        take_line();
        check("gap_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
